speed_pi_pwm: RTL and testbench

//  Closed-loop stage downstream of the hall edge counter. Each new edges-per-second measurement is compared to a

---
 rtl/speed_pi_pwm.sv | 143 ++++++++++++++
 tb/tb_speed_pi_pwm.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_pi_pwm.sv
// Speed regulator: PI controller on edges-per-second measurements driving
// a fixed-period PWM whose duty is swapped only at period boundaries.
module speed_pi_pwm #(
    parameter int PWM_PERIOD = 1000,
    parameter int DUTY_W     = 10,
    parameter int SHIFT      = 8,
    parameter int ERR_MAX    = 32767,
    parameter int INT_MAX    = 8388607
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [31:0]       meas_count,
    input  logic              meas_valid,
    input  logic [31:0]       setpoint,
    input  logic [7:0]        kp,
    input  logic [7:0]        ki,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] duty,
    output logic              busy,
    output logic              sat,
    output logic              overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ERR   = 2'd1;
    localparam logic [1:0] S_CALC  = 2'd2;
    localparam logic [1:0] S_CLAMP = 2'd3;

    localparam logic signed [32:0] ERR_HI = 33'(ERR_MAX);
    localparam logic signed [32:0] ERR_LO = -ERR_HI;
    localparam logic signed [25:0] INT_HI = 26'(INT_MAX);
    localparam logic signed [25:0] INT_LO = -INT_HI;
    localparam logic signed [26:0] U_MAX  = 27'(PWM_PERIOD);
    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_PERIOD - 1);
    localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(PWM_PERIOD);

    logic [1:0]         state;
    logic [31:0]        meas_q;
    logic [31:0]        sp_q;
    logic signed [15:0] err_q;
    logic signed [25:0] inext_q;
    logic signed [26:0] u_q;
    logic signed [23:0] integ;
    logic [DUTY_W-1:0]  duty_new;
    logic [DUTY_W-1:0]  cnt;

    logic signed [32:0] diff;
    logic signed [15:0] err_c;
    logic signed [24:0] p_c;
    logic signed [24:0] ki_term;
    logic signed [25:0] inext_c;
    logic signed [26:0] sum_c;
    logic signed [26:0] u_c;
    logic               u_hi;
    logic               u_lo;
    logic               hold;
    logic signed [23:0] integ_clip;
    logic [DUTY_W-1:0]  duty_c;
    logic               wrap;

    // Error is taken from the measurement latched at acceptance time
    assign diff = $signed({1'b0, sp_q}) - $signed({1'b0, meas_q});
    assign err_c = (diff > ERR_HI) ? ERR_HI[15:0] :
                   (diff < ERR_LO) ? ERR_LO[15:0] : diff[15:0];

    assign p_c     = 25'($signed({1'b0, kp})) * 25'(err_q);
    assign ki_term = 25'($signed({1'b0, ki})) * 25'(err_q);
    assign inext_c = 26'(integ) + 26'(ki_term);
    assign sum_c   = 27'(p_c) + 27'(inext_c);
    assign u_c     = sum_c >>> SHIFT;

    assign u_lo = u_q[26];
    assign u_hi = u_q > U_MAX;
    // Freeze the integrator while it would only push deeper into saturation
    assign hold = (u_hi && (err_q > 16'sd0)) || (u_lo && err_q[15]);
    assign integ_clip = (inext_q > INT_HI) ? INT_HI[23:0] :
                        (inext_q < INT_LO) ? INT_LO[23:0] : inext_q[23:0];
    assign duty_c = u_lo ? '0 : u_hi ? DUTY_FULL : u_q[DUTY_W-1:0];

    assign busy    = (state != S_IDLE);
    assign overrun = meas_valid && enable && busy;
    assign wrap    = (cnt == CNT_LAST);
    assign pwm_out = (cnt < duty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            meas_q   <= '0;
            sp_q     <= '0;
            err_q    <= '0;
            inext_q  <= '0;
            u_q      <= '0;
            integ    <= '0;
            duty_new <= '0;
            sat      <= 1'b0;
        end else if (!enable) begin
            state    <= S_IDLE;
            integ    <= '0;
            duty_new <= '0;
            sat      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (meas_valid) begin
                        meas_q <= meas_count;
                        sp_q   <= setpoint;
                        state  <= S_ERR;
                    end
                end
                S_ERR: begin
                    err_q <= err_c;
                    state <= S_CALC;
                end
                S_CALC: begin
                    inext_q <= inext_c;
                    u_q     <= u_c;
                    state   <= S_CLAMP;
                end
                S_CLAMP: begin
                    duty_new <= duty_c;
                    sat      <= u_hi || u_lo;
                    if (!hold) integ <= integ_clip;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Counter free-runs; duty only changes at the wrap unless disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            duty <= '0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (!enable) duty <= '0;
            else if (wrap) duty <= duty_new;
        end
    end

endmodule

// File: tb/tb_speed_pi_pwm.sv
// Self-checking bench for speed_pi_pwm: directed scenarios plus randomized
// strobes compared against an arithmetic PI/PWM reference model.
module tb_speed_pi_pwm;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] meas_count;
    logic        meas_valid;
    logic [31:0] setpoint;
    logic [7:0]  kp;
    logic [7:0]  ki;
    logic        pwm_out;
    logic [9:0]  duty;
    logic        busy;
    logic        sat;
    logic        overrun;

    int n_pass  = 0;
    int n_total = 0;

    longint m_integ;
    int     exp_duty;
    bit     exp_sat;
    int     mcnt;

    speed_pi_pwm dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .meas_count(meas_count),
        .meas_valid(meas_valid),
        .setpoint  (setpoint),
        .kp        (kp),
        .ki        (ki),
        .pwm_out   (pwm_out),
        .duty      (duty),
        .busy      (busy),
        .sat       (sat),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Reference position within the PWM period
    always @(posedge clk or posedge reset) begin
        if (reset) mcnt <= 0;
        else mcnt <= (mcnt + 1) % 1000;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference controller: err clip, PI sum, floor shift, clamp, anti-windup
    task automatic model_step();
        longint err;
        longint inext;
        longint u;
        err = longint'(setpoint) - longint'(meas_count);
        if (err > 32767) err = 32767;
        if (err < -32767) err = -32767;
        inext = m_integ + longint'(ki) * err;
        u = (longint'(kp) * err + inext) >>> 8;
        exp_sat = (u < 0) || (u > 1000);
        exp_duty = (u < 0) ? 0 : (u > 1000) ? 1000 : int'(u);
        if (!((u > 1000 && err > 0) || (u < 0 && err < 0))) begin
            if (inext > 8388607) inext = 8388607;
            if (inext < -8388607) inext = -8388607;
            m_integ = inext;
        end
    endtask

    task automatic strobe();
        model_step();
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic wait_wrap();
        int n = 0;
        do begin
            tick();
            n++;
        end while (mcnt != 0 && n < 1100);
        if (mcnt != 0) begin
            n_total++;
            $display("FAIL wrap_timeout: mcnt=%0d after %0d cycles", mcnt, n);
        end
    endtask

    task automatic count_high(output int hi);
        hi = 0;
        for (int i = 0; i < 1000; i++) begin
            hi += int'(pwm_out);
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        meas_valid = 1'b0;
        meas_count = '0;
        setpoint = '0;
        kp = '0;
        ki = '0;
        m_integ = 0;
        repeat (3) tick();
        n_total++;
        if ({pwm_out, duty, busy, sat, overrun} !== 14'd0)
            $display("FAIL reset_outputs: got %b want 0",
                     {pwm_out, duty, busy, sat, overrun});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) tick();
        n_total++;
        if (duty !== 10'd0 || pwm_out !== 1'b0 || busy !== 1'b0)
            $display("FAIL post_reset: duty=%0d pwm=%b busy=%b want 0",
                     duty, pwm_out, busy);
        else n_pass++;
    endtask

    task automatic test_proportional();
        int hi;
        bit [3:0] bseq;
        kp = 8'd16; ki = 8'd0;
        setpoint = 32'd100; meas_count = 32'd50;
        model_step();
        meas_valid = 1'b1;
        #1 bseq[0] = busy;
        tick();
        meas_valid = 1'b0;
        bseq[1] = busy;
        tick();
        bseq[2] = busy;
        tick();
        bseq[3] = busy;
        tick();
        n_total++;
        if (bseq !== 4'b1110 || busy !== 1'b0)
            $display("FAIL busy_window: got %b,%b want 1110,0", bseq, busy);
        else n_pass++;
        n_total++;
        if (sat !== exp_sat)
            $display("FAIL p_sat: got %b want %b", sat, exp_sat);
        else n_pass++;
        wait_wrap();
        n_total++;
        if (duty !== 10'(exp_duty))
            $display("FAIL p_duty: got %0d want %0d", duty, exp_duty);
        else n_pass++;
        count_high(hi);
        n_total++;
        if (hi != exp_duty)
            $display("FAIL p_high_cycles: got %0d want %0d", hi, exp_duty);
        else n_pass++;
    endtask

    task automatic test_integral();
        kp = 8'd0; ki = 8'd1;
        setpoint = 32'd256; meas_count = 32'd0;
        for (int k = 1; k <= 5; k++) begin
            strobe();
            n_total++;
            if (sat !== exp_sat)
                $display("FAIL i_sat_%0d: got %b want %b", k, sat, exp_sat);
            else n_pass++;
            wait_wrap();
            n_total++;
            if (duty !== 10'(exp_duty))
                $display("FAIL i_duty_%0d: got %0d want %0d",
                         k, duty, exp_duty);
            else n_pass++;
            repeat (1000) tick();
        end
    endtask

    task automatic test_sat_high();
        int hi;
        kp = 8'd255; ki = 8'd0;
        setpoint = 32'd40000; meas_count = 32'd0;
        strobe();
        n_total++;
        if (sat !== 1'b1 || exp_sat !== 1'b1)
            $display("FAIL hi_sat: got %b want 1", sat);
        else n_pass++;
        wait_wrap();
        n_total++;
        if (duty !== 10'(exp_duty))
            $display("FAIL hi_duty: got %0d want %0d", duty, exp_duty);
        else n_pass++;
        count_high(hi);
        n_total++;
        if (hi != 1000)
            $display("FAIL hi_high_cycles: got %0d want 1000", hi);
        else n_pass++;
        ki = 8'd1;
        for (int k = 0; k < 3; k++) begin
            strobe();
            wait_wrap();
            n_total++;
            if (duty !== 10'(exp_duty) || sat !== exp_sat)
                $display("FAIL windup_%0d: duty=%0d sat=%b want %0d,%b",
                         k, duty, sat, exp_duty, exp_sat);
            else n_pass++;
        end
        kp = 8'd0;
        setpoint = 32'd256;
        strobe();
        wait_wrap();
        n_total++;
        if (duty !== 10'(exp_duty))
            $display("FAIL antiwindup: got %0d want %0d", duty, exp_duty);
        else n_pass++;
    endtask

    task automatic test_sat_low();
        int hi;
        kp = 8'd16; ki = 8'd0;
        setpoint = 32'd0; meas_count = 32'd5000;
        strobe();
        n_total++;
        if (sat !== 1'b1 || exp_sat !== 1'b1)
            $display("FAIL lo_sat: got %b want 1", sat);
        else n_pass++;
        wait_wrap();
        n_total++;
        if (duty !== 10'd0)
            $display("FAIL lo_duty: got %0d want 0", duty);
        else n_pass++;
        count_high(hi);
        n_total++;
        if (hi != 0)
            $display("FAIL lo_high_cycles: got %0d want 0", hi);
        else n_pass++;
    endtask

    task automatic test_overrun();
        bit [2:0] oseq;
        int old_duty;
        int bad;
        int n;
        kp = 8'd16; ki = 8'd0;
        setpoint = 32'd100; meas_count = 32'd50;
        model_step();
        meas_valid = 1'b1;
        #1 oseq[0] = overrun;
        tick();
        meas_count = 32'd0;
        #1 oseq[1] = overrun;
        tick();
        meas_valid = 1'b0;
        #1 oseq[2] = overrun;
        tick();
        tick();
        n_total++;
        if (oseq !== 3'b010)
            $display("FAIL overrun_pulse: got %b want 010", oseq);
        else n_pass++;
        wait_wrap();
        n_total++;
        if (duty !== 10'(exp_duty))
            $display("FAIL overrun_duty: got %0d want %0d", duty, exp_duty);
        else n_pass++;
        old_duty = exp_duty;
        n = 0;
        while (mcnt != 500 && n < 1100) begin
            tick();
            n++;
        end
        model_step();
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        bad = 0;
        n = 0;
        while (mcnt != 0 && n < 1100) begin
            if (duty !== 10'(old_duty)) bad++;
            tick();
            n++;
        end
        n_total++;
        if (bad != 0 || mcnt != 0)
            $display("FAIL midperiod_hold: bad=%0d mcnt=%0d want 0,0",
                     bad, mcnt);
        else n_pass++;
        n_total++;
        if (duty !== 10'(exp_duty))
            $display("FAIL midperiod_new: got %0d want %0d", duty, exp_duty);
        else n_pass++;
    endtask

    task automatic test_enable();
        kp = 8'd16; ki = 8'd1;
        setpoint = 32'd4800; meas_count = 32'd0;
        strobe();
        wait_wrap();
        n_total++;
        if (duty !== 10'(exp_duty))
            $display("FAIL en_setup: got %0d want %0d", duty, exp_duty);
        else n_pass++;
        repeat (20) tick();
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        tick();
        enable = 1'b0;
        tick();
        m_integ = 0;
        n_total++;
        if ({duty, pwm_out, busy, sat} !== 13'd0)
            $display("FAIL disable: duty=%0d pwm=%b busy=%b sat=%b want 0",
                     duty, pwm_out, busy, sat);
        else n_pass++;
        meas_valid = 1'b1;
        #1;
        n_total++;
        if (overrun !== 1'b0)
            $display("FAIL disabled_overrun: got %b want 0", overrun);
        else n_pass++;
        tick();
        meas_valid = 1'b0;
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL disabled_busy: got %b want 0", busy);
        else n_pass++;
        enable = 1'b1;
        kp = 8'd0; ki = 8'd1;
        setpoint = 32'd256;
        strobe();
        wait_wrap();
        n_total++;
        if (duty !== 10'(exp_duty))
            $display("FAIL reenable_integ: got %0d want %0d", duty, exp_duty);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n;
        kp = 8'd255; ki = 8'd0;
        setpoint = 32'd40000; meas_count = 32'd0;
        strobe();
        wait_wrap();
        n = 0;
        while (mcnt != 200 && n < 1100) begin
            tick();
            n++;
        end
        n_total++;
        if (pwm_out !== 1'b1 || sat !== 1'b1)
            $display("FAIL pre_reset: pwm=%b sat=%b want 1,1", pwm_out, sat);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        m_integ = 0;
        n_total++;
        if ({pwm_out, duty, busy, sat, overrun} !== 14'd0)
            $display("FAIL reset_mid_period: got %b want 0",
                     {pwm_out, duty, busy, sat, overrun});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        tick();
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        n_total++;
        if (busy !== 1'b0 || duty !== 10'd0)
            $display("FAIL reset_mid_calc: busy=%b duty=%0d want 0,0",
                     busy, duty);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            kp = 8'($urandom_range(0, 255));
            ki = 8'($urandom_range(0, 4));
            setpoint = $urandom_range(0, 30000);
            meas_count = $urandom_range(0, 30000);
            if ($urandom_range(0, 3) == 0) setpoint = $urandom;
            strobe();
            n_total++;
            if (sat !== exp_sat)
                $display("FAIL rnd_sat_%0d: got %b want %b", k, sat, exp_sat);
            else n_pass++;
            wait_wrap();
            n_total++;
            if (duty !== 10'(exp_duty))
                $display("FAIL rnd_duty_%0d: got %0d want %0d",
                         k, duty, exp_duty);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_proportional();
        test_integral();
        test_sat_high();
        test_sat_low();
        test_overrun();
        test_enable();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
